// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing, widths and capture FSM states; also used by the VGA controller.
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;

  localparam int PIX_W   = 3;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 12;

  typedef enum logic [1:0] {WAIT_VSYNC, WAIT_HSYNC, LOCKED} cap_state_e;

  // CRC-16-CCITT (poly 0x1021), one byte MSB first.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// Sync input stage: polarity normalisation, stage-1 register, delayed copy and assert-edge detect.
module vga_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_raw,
  output logic edge_det
);
  logic sync_s1, sync_d;

  // Both copies reset to "asserted" so only a real deassert->assert after reset counts as an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_s1 <= 1'b1;
      sync_d  <= 1'b1;
    end else begin
      sync_s1 <= sync_raw ^ ACTIVE_LOW;
      sync_d  <= sync_s1;
    end
  end

  assign edge_det = sync_s1 & ~sync_d;
endmodule

// File: rtl/vga_capture.sv
// VGA receive-side capture: recovers raster position from syncs, writes active pixels, flags timing errors.
// Optional per-frame CRC-16 enabled by defining VGA_CAPTURE_CRC_EN.
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [PIX_W-1:0]   pixel_in,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [PIX_W-1:0]   wr_pixel,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_error,
  output logic [7:0]         error_count,
  output logic [15:0]        frame_count,
  output logic [15:0]        frame_crc
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic             h_edge, v_edge, vs_pend;
  logic [PIX_W-1:0] pix_s1;
  cap_state_e       state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_cur, v_cur, h_nxt, v_nxt;
  logic             pending, pending_nxt, viol, wr_ok, last_px;

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs (
    .clock(clock), .reset(reset), .sync_raw(hsync), .edge_det(h_edge));
  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs (
    .clock(clock), .reset(reset), .sync_raw(vsync), .edge_det(v_edge));

  always_ff @(posedge clock) begin
    if (reset) pix_s1 <= '0;
    else       pix_s1 <= pixel_in;
  end

  assign vs_pend = pending | v_edge;
  assign locked  = (state == LOCKED);

  // h_cnt/v_cnt hold the previous stage-1 sample's position; h_cur/v_cur are the current sample's.
  always_comb begin
    state_nxt   = state;
    viol        = 1'b0;
    h_nxt       = '0;
    v_nxt       = '0;
    pending_nxt = 1'b0;
    h_cur       = h_edge ? '0 : h_cnt + CNT_W'(1);
    v_cur       = h_edge ? (vs_pend ? '0 : v_cnt + CNT_W'(1)) : v_cnt;
    case (state)
      WAIT_VSYNC: begin
        if (v_edge && h_edge) state_nxt = LOCKED;
        else if (v_edge)      state_nxt = WAIT_HSYNC;
      end
      WAIT_HSYNC: if (h_edge) state_nxt = LOCKED;
      LOCKED: begin
        viol = (h_edge && h_cnt != H_LAST) || (!h_edge && h_cnt == H_LAST) ||
               (h_edge && vs_pend && v_cnt != V_LAST) || (h_edge && !vs_pend && v_cnt == V_LAST);
        if (viol) state_nxt = WAIT_VSYNC;
        else begin
          h_nxt       = h_cur;
          v_nxt       = v_cur;
          pending_nxt = !h_edge && vs_pend;
        end
      end
      default: state_nxt = WAIT_VSYNC;
    endcase
  end

  assign wr_ok = locked && !viol && h_cur >= H_START && h_cur < H_END &&
                 v_cur >= V_START && v_cur < V_END;
  assign last_px = wr_ok && h_cur == H_END - CNT_W'(1) && v_cur == V_END - CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_VSYNC;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pending     <= 1'b0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_pixel    <= '0;
      frame_done  <= 1'b0;
      sync_error  <= 1'b0;
      error_count <= '0;
      frame_count <= '0;
    end else begin
      state      <= state_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      pending    <= pending_nxt;
      wr_en      <= wr_ok;
      frame_done <= last_px;
      sync_error <= viol;
      if (wr_ok) begin
        wr_x     <= COORD_W'(h_cur - H_START);
        wr_y     <= COORD_W'(v_cur - V_START);
        wr_pixel <= pix_s1;
      end
      if (viol && error_count != 8'hFF) error_count <= error_count + 8'd1;
      if (last_px) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;

  assign crc_nxt = crc16_ccitt_byte(crc, 8'(pix_s1));

  always_ff @(posedge clock) begin
    if (reset) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else if (viol) begin
      crc <= 16'hFFFF;
    end else if (wr_ok) begin
      if (last_px) begin
        frame_crc <= crc_nxt;
        crc       <= 16'hFFFF;
      end else begin
        crc <= crc_nxt;
      end
    end
  end
`else
  assign frame_crc = '0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken 16x9 raster (8x4 active) with a behavioural sync source.
module tb_vga_capture;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clock = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1;
  logic [2:0] pixel_in = 3'd0;
  logic wr_en, frame_done, locked, sync_error;
  logic [9:0] wr_x, wr_y;
  logic [2:0] wr_pixel;
  logic [7:0] error_count;
  logic [15:0] frame_count, frame_crc;

  int checks = 0, errors = 0, cyc = 0;
  logic [23:0] wq[$], eq[$];
  int err_pulses = 0, stray_fd = 0, first_wr_cyc = -1, first_drv_cyc = -1;
  bit err_locked = 1'b0, zero_pix = 1'b0;

  vga_capture #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync), .pixel_in(pixel_in),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .frame_done(frame_done), .locked(locked), .sync_error(sync_error),
    .error_count(error_count), .frame_count(frame_count), .frame_crc(frame_crc)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL timeout cycles %0d limit 20000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  end

  // Write log: {frame_done, pixel, y, x} per write.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      wq.push_back({frame_done, wr_pixel, wr_y, wr_x});
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (frame_done === 1'b1 && wr_en !== 1'b1) stray_fd++;
    if (sync_error === 1'b1) begin
      err_pulses++;
      if (locked !== 1'b0) err_locked = 1'b1;
    end
  end

  task automatic clear_mon;
    wq.delete(); eq.delete();
    err_pulses = 0; stray_fd = 0; first_wr_cyc = -1; first_drv_cyc = -1; err_locked = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clock);
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; pixel_in = 3'd0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    clear_mon();
  endtask

  // Sample s of a frame; hc=0 is the start of the hsync pulse, vc=0 the first vsync line.
  task automatic drive_sample(input int s, input bit vs_en, input int gl_line, input int gl_h);
    int vc, hc, x, y;
    bit hs_a, vs_a, act;
    vc = s / HT; hc = s % HT;
    x = hc - (HS + HB); y = vc - (VS + VB);
    hs_a = (hc < HS) || (vc == gl_line && (hc == gl_h || hc == gl_h + 1));
    vs_a = vs_en && (vc < VS);
    act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    @(negedge clock);
    hsync = ~hs_a; vsync = ~vs_a;
    pixel_in = (act && !zero_pix) ? 3'(x + y) : 3'd0;
    if (act && first_drv_cyc < 0) first_drv_cyc = cyc;
  endtask

  task automatic drive_span(input int from, input int to, input bit vs_en, input int gl_line, input int gl_h);
    for (int s = from; s < to; s++) drive_sample(s, vs_en, gl_line, gl_h);
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clock);
      hsync = 1'b1; vsync = 1'b1; pixel_in = 3'd0;
    end
  endtask

  // Start the next frame so the previous one ends cleanly, then let the pipeline drain.
  task automatic lead_and_settle;
    drive_span(0, 2, 1'b1, -1, -1);
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic exp_raster(input int n);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = i % HA; y = (i / HA) % VA;
      eq.push_back({(x == HA - 1) && (y == VA - 1), 3'(x + y), 10'(y), 10'(x)});
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    #1;
    checks++; if ({wr_en, frame_done, locked, sync_error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {wr_en, frame_done, locked, sync_error}); end
    checks++; if (wr_x !== 10'd0) begin errors++; $display("FAIL reset_wr_x got %0d want 0", wr_x); end
    checks++; if (wr_y !== 10'd0) begin errors++; $display("FAIL reset_wr_y got %0d want 0", wr_y); end
    checks++; if (wr_pixel !== 3'd0) begin errors++; $display("FAIL reset_wr_pixel got %0d want 0", wr_pixel); end
    checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL reset_error_count got %0d want 0", error_count); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    checks++; if (frame_crc !== 16'd0) begin errors++; $display("FAIL reset_frame_crc got %h want 0000", frame_crc); end
  endtask

  task automatic test_clean_frames;
    apply_reset();
    drive_idle(3);
    drive_span(0, FRAME, 1'b1, -1, -1);
    drive_span(0, FRAME, 1'b1, -1, -1);
    lead_and_settle();
    exp_raster(2 * HA * VA);
    checks++; if (wq.size() != eq.size()) begin errors++; $display("FAIL clean_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      checks++; if (wq[i] !== eq[i]) begin errors++; $display("FAIL clean_write[%0d] got %h want %h", i, wq[i], eq[i]); end
    end
    checks++; if (first_wr_cyc - first_drv_cyc != 2) begin errors++; $display("FAIL clean_latency got %0d want 2", first_wr_cyc - first_drv_cyc); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL clean_frame_count got %0d want 2", frame_count); end
    checks++; if (err_pulses != 0 || error_count !== 8'd0) begin errors++; $display("FAIL clean_errors got %0d/%0d want 0/0", err_pulses, error_count); end
    checks++; if (stray_fd != 0) begin errors++; $display("FAIL clean_stray_frame_done got %0d want 0", stray_fd); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_locked got %b want 1", locked); end
  endtask

  task automatic test_hsync_glitch;
    apply_reset();
    drive_idle(3);
    drive_span(0, FRAME, 1'b1, -1, -1);
    drive_span(0, FRAME, 1'b1, VS + VB + 1, HT - 4);
    drive_span(0, FRAME, 1'b1, -1, -1);
    lead_and_settle();
    exp_raster(HA * VA);
    exp_raster(HA + (HT - 4) - (HS + HB));
    exp_raster(HA * VA);
    checks++; if (wq.size() != eq.size()) begin errors++; $display("FAIL glitch_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      checks++; if (wq[i] !== eq[i]) begin errors++; $display("FAIL glitch_write[%0d] got %h want %h", i, wq[i], eq[i]); end
    end
    checks++; if (err_pulses != 1) begin errors++; $display("FAIL glitch_pulses got %0d want 1", err_pulses); end
    checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL glitch_error_count got %0d want 1", error_count); end
    checks++; if (err_locked !== 1'b0) begin errors++; $display("FAIL glitch_locked_at_error got %b want 0", err_locked); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL glitch_frame_count got %0d want 2", frame_count); end
  endtask

  task automatic test_missing_vsync;
    apply_reset();
    drive_idle(3);
    drive_span(0, FRAME, 1'b1, -1, -1);
    drive_span(0, FRAME, 1'b0, -1, -1);
    drive_span(0, FRAME, 1'b1, -1, -1);
    lead_and_settle();
    exp_raster(2 * HA * VA);
    checks++; if (wq.size() != eq.size()) begin errors++; $display("FAIL novsync_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      checks++; if (wq[i] !== eq[i]) begin errors++; $display("FAIL novsync_write[%0d] got %h want %h", i, wq[i], eq[i]); end
    end
    checks++; if (err_pulses != 1 || error_count !== 8'd1) begin errors++; $display("FAIL novsync_errors got %0d/%0d want 1/1", err_pulses, error_count); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL novsync_frame_count got %0d want 2", frame_count); end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    drive_idle(3);
    drive_span(0, FRAME, 1'b1, -1, -1);
    drive_span(0, 6 * HT + 8, 1'b1, -1, -1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checks++; if ({wr_en, frame_done, locked, sync_error} !== 4'b0) begin errors++; $display("FAIL midreset_flags got %b want 0000", {wr_en, frame_done, locked, sync_error}); end
    checks++; if (frame_count !== 16'd0 || wr_x !== 10'd0 || wr_y !== 10'd0) begin errors++; $display("FAIL midreset_regs got fc=%0d x=%0d y=%0d want 0", frame_count, wr_x, wr_y); end
    reset = 1'b0;
    clear_mon();
    drive_span(6 * HT + 8, FRAME, 1'b1, -1, -1);
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL midreset_early_writes got %0d want 0", wq.size()); end
    drive_span(0, FRAME, 1'b1, -1, -1);
    lead_and_settle();
    exp_raster(HA * VA);
    checks++; if (wq.size() != eq.size()) begin errors++; $display("FAIL midreset_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      checks++; if (wq[i] !== eq[i]) begin errors++; $display("FAIL midreset_write[%0d] got %h want %h", i, wq[i], eq[i]); end
    end
    checks++; if (frame_count !== 16'd1 || err_pulses != 0) begin errors++; $display("FAIL midreset_tail got fc=%0d err=%0d want 1/0", frame_count, err_pulses); end
  endtask

  task automatic test_crc;
    logic [15:0] want;
    apply_reset();
    drive_idle(3);
    zero_pix = 1'b1;
    drive_span(0, FRAME, 1'b1, -1, -1);
    zero_pix = 1'b0;
    lead_and_settle();
`ifdef VGA_CAPTURE_CRC_EN
    want = 16'hFFFF;
    for (int n = 0; n < HA * VA; n++) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = want[15] ^ 1'b0;
        want = {want[14:0], 1'b0};
        if (fb) want = want ^ 16'h1021;
      end
    end
`else
    want = 16'h0000;
`endif
    checks++; if (frame_crc !== want) begin errors++; $display("FAIL crc_value got %h want %h", frame_crc, want); end
    checks++; if (frame_count !== 16'd1 || wq.size() != HA * VA) begin errors++; $display("FAIL crc_frame got fc=%0d writes=%0d want 1/%0d", frame_count, wq.size(), HA * VA); end
  endtask

  // Lock on a joint sync edge, then an early hsync two samples later.
  task automatic viol_burst(input int n);
    repeat (n) begin
      @(negedge clock); hsync = 1'b0; vsync = 1'b0;
      @(negedge clock); hsync = 1'b1; vsync = 1'b1;
      @(negedge clock); hsync = 1'b0; vsync = 1'b1;
      @(negedge clock); hsync = 1'b1; vsync = 1'b1;
    end
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic test_saturate;
    apply_reset();
    drive_idle(2);
    viol_burst(254);
    checks++; if (error_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", error_count); end
    viol_burst(1);
    checks++; if (error_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", error_count); end
    viol_burst(45);
    checks++; if (error_count !== 8'd255) begin errors++; $display("FAIL sat_300 got %0d want 255", error_count); end
    checks++; if (err_pulses != 300) begin errors++; $display("FAIL sat_pulses got %0d want 300", err_pulses); end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL sat_writes got %0d want 0", wq.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_hsync_glitch();
    test_missing_vsync();
    test_reset_mid();
    test_crc();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
